memstage_sized: RTL and testbench

- Parametrised next-generation data-memory stage for the pipelined datapath.
- Adds byte/halfword/word loads and stores (sign or zero extension), a configurable wait-state memory handshake and misaligned-access detection on top of a word-addressed RAM.
- Sits between the EX/MEM pipeline register and write-back.
- The pipeline issues one request and stalls on `busy` until `ready` pulses.

---
 rtl/memstage_sized.sv | 177 +++++++++++++++++
 tb/tb_memstage_sized.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/memstage_sized.sv
//==============================================================================
// memstage_sized : data-memory stage, byte/half/word loads+stores, wait states
// Rev 1.0 | optional macro MEMSTAGE_MISALIGN_TRAP_EN (reject misaligned access)
//==============================================================================
`default_nettype none

module memstage_sized #(
   parameter int ADDR_BITS   = 10,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        Mem_WrEn,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] ALU_MEM_Addr,
   input  logic [31:0] MEM_DataIn,
   output logic [31:0] MEM_DataOut,
   output logic        busy,
   output logic        ready,
   output logic        misaligned
);

   localparam int               BA_W       = ADDR_BITS + 2;
   localparam int               CNT_W      = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
   localparam logic [CNT_W-1:0] C_CNT_INIT = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_ACCESS = 2'd2
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic [BA_W-1:0]   r_addr, w_addr_al;
   logic [31:0]       r_wdata, r_dout, w_rword, w_lane, w_load, w_wlane;
   logic [1:0]        r_size;
   logic              r_sext, r_we, r_ready, r_mis;
   logic              w_accept, w_mis_req, w_ready_nxt, w_mis_nxt;
   logic [3:0]        w_be;
   logic [31:0]       r_mem [0:(1<<ADDR_BITS)-1];
   logic              w_unused_addr;

   assign w_unused_addr = ^ALU_MEM_Addr[31:BA_W];

`ifdef MEMSTAGE_MISALIGN_TRAP_EN
   always_comb begin
      w_mis_req = ((size == 2'b01) && ALU_MEM_Addr[0]) ||
                  (size[1] && (ALU_MEM_Addr[1:0] != 2'b00));
      w_addr_al = ALU_MEM_Addr[BA_W-1:0];
   end
`else
   // Without the trap, misaligned addresses are silently truncated to the access size.
   always_comb begin
      w_mis_req = 1'b0;
      w_addr_al = ALU_MEM_Addr[BA_W-1:0];
      if (size[1])
         w_addr_al[1:0] = 2'b00;
      else if (size[0])
         w_addr_al[0] = 1'b0;
   end
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ready_nxt = 1'b0;
      w_mis_nxt   = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req) begin
               if (w_mis_req) begin
                  w_ready_nxt = 1'b1;
                  w_mis_nxt   = 1'b1;
               end else begin
                  w_accept = 1'b1;
                  if (WAIT_STATES > 0) begin
                     w_state_nxt = S_WAIT;
                     w_cnt_nxt   = C_CNT_INIT;
                  end else begin
                     w_state_nxt = S_ACCESS;
                  end
               end
            end
         end
         S_WAIT: begin
            if (r_cnt == '0)
               w_state_nxt = S_ACCESS;
            else
               w_cnt_nxt = r_cnt - CNT_W'(1);
         end
         S_ACCESS: begin
            w_state_nxt = S_IDLE;
            w_ready_nxt = 1'b1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_ready <= 1'b0;
         r_mis   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_size  <= 2'b00;
         r_sext  <= 1'b0;
         r_we    <= 1'b0;
         r_dout  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ready <= w_ready_nxt;
         r_mis   <= w_mis_nxt;
         if (w_accept) begin
            r_addr  <= w_addr_al;
            r_wdata <= MEM_DataIn;
            r_size  <= size;
            r_sext  <= sign_ext;
            r_we    <= Mem_WrEn;
         end
         if (r_state == S_ACCESS && !r_we)
            r_dout <= w_load;
      end
   end

   // Load path: shift the addressed lane down to bit 0, then extend.
   always_comb begin
      w_rword = r_mem[r_addr[BA_W-1:2]];
      w_lane  = w_rword >> {r_addr[1:0], 3'b000};
      case (r_size)
         2'b00:   w_load = r_sext ? {{24{w_lane[7]}},  w_lane[7:0]}  : {24'd0, w_lane[7:0]};
         2'b01:   w_load = r_sext ? {{16{w_lane[15]}}, w_lane[15:0]} : {16'd0, w_lane[15:0]};
         default: w_load = w_rword;
      endcase
   end

   // Store path: replicate data across lanes and let the byte enables pick.
   always_comb begin
      case (r_size)
         2'b00: begin
            w_be    = 4'b0001 << r_addr[1:0];
            w_wlane = {4{r_wdata[7:0]}};
         end
         2'b01: begin
            w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
            w_wlane = {2{r_wdata[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wlane = r_wdata;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (r_state == S_ACCESS && r_we) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i])
               r_mem[r_addr[BA_W-1:2]][8*i +: 8] <= w_wlane[8*i +: 8];
         end
      end
   end

   assign busy        = (r_state != S_IDLE);
   assign ready       = r_ready;
   assign misaligned  = r_mis;
   assign MEM_DataOut = r_dout;

endmodule

`default_nettype wire

// File: tb/tb_memstage_sized.sv
//==============================================================================
// tb_memstage_sized : randomized self-checking bench with byte-array memory model
// Rev 1.0 | follows MEMSTAGE_MISALIGN_TRAP_EN to pick expected behaviour
//==============================================================================
`default_nettype none

module tb_memstage_sized;

   localparam int WS = 1;
`ifdef MEMSTAGE_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, req, Mem_WrEn, sign_ext;
   logic [1:0]  size;
   logic [31:0] ALU_MEM_Addr, MEM_DataIn, MEM_DataOut;
   logic        busy, ready, misaligned;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] exp_dout = '0;
   logic [7:0]  mem_m [0:4095];

   memstage_sized #(.ADDR_BITS(10), .WAIT_STATES(WS)) dut (
      .clk(clk), .reset(reset), .req(req), .Mem_WrEn(Mem_WrEn), .size(size),
      .sign_ext(sign_ext), .ALU_MEM_Addr(ALU_MEM_Addr), .MEM_DataIn(MEM_DataIn),
      .MEM_DataOut(MEM_DataOut), .busy(busy), .ready(ready), .misaligned(misaligned)
   );

   always #5 clk = ~clk;

   // ---------------- reference model: flat byte array, 4 KiB wrap ----------------
   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic int eff_idx(input logic [1:0] sz, input logic [31:0] a);
      int idx;
      idx = int'({20'd0, a[11:0]});
      if (!TRAP) idx = idx - (idx % nbytes(sz));
      return idx;
   endfunction

   function automatic bit model_mis(input logic [1:0] sz, input logic [31:0] a);
      return TRAP && (((sz == 2'd1) && a[0]) || (sz[1] && (a[1:0] != 2'b00)));
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sx, input logic [31:0] a);
      logic [31:0] v;
      int idx, n;
      v = '0; idx = eff_idx(sz, a); n = nbytes(sz);
      for (int i = 0; i < n; i++) v[8*i +: 8] = mem_m[idx + i];
      if (sx && n == 1) v = {{24{v[7]}}, v[7:0]};
      if (sx && n == 2) v = {{16{v[15]}}, v[15:0]};
      return v;
   endfunction

   task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
      int idx;
      idx = eff_idx(sz, a);
      for (int i = 0; i < nbytes(sz); i++) mem_m[idx + i] = d[8*i +: 8];
   endtask

   // ---------------- stimulus driver: returns observations only ----------------
   task automatic access(input logic we, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d,
                         output int rdy_cyc, output logic mis_o,
                         output logic [31:0] dout_o, output logic busy_ok);
      int cyc;
      @(negedge clk);
      req = 1'b1; Mem_WrEn = we; size = sz; sign_ext = sx; ALU_MEM_Addr = a; MEM_DataIn = d;
      cyc = 0; rdy_cyc = -1; mis_o = 1'b0; dout_o = 'x; busy_ok = 1'b1;
      while (rdy_cyc < 0 && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (ready) begin
            rdy_cyc = cyc; mis_o = misaligned; dout_o = MEM_DataOut;
            if (busy) busy_ok = 1'b0;
         end else if (!busy) begin
            busy_ok = 1'b0;
         end
         req = 1'b0;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; req = 1'b0; Mem_WrEn = 1'b0; size = 2'd0; sign_ext = 1'b0;
      ALU_MEM_Addr = '0; MEM_DataIn = '0;
      repeat (3) @(negedge clk);
      n_checks++; if ({busy, ready, misaligned, MEM_DataOut} !== 35'd0) $display("FAIL reset_held: got %h exp 0", {busy, ready, misaligned, MEM_DataOut}); else n_pass++;
      reset = 1'b0;
      @(negedge clk);
      n_checks++; if ({busy, ready, misaligned, MEM_DataOut} !== 35'd0) $display("FAIL reset_release: got %h exp 0", {busy, ready, misaligned, MEM_DataOut}); else n_pass++;
   endtask

   task automatic test_directed;
      int rc; logic m, bo; logic [31:0] q;
      access(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, rc, m, q, bo); model_store(2'd2, 32'h100, 32'hDEADBEEF);
      n_checks++; if (rc !== WS + 2 || !bo) $display("FAIL sw_timing: ready cyc %0d busy_ok %0d exp %0d 1", rc, bo, WS + 2); else n_pass++;
      n_checks++; if (q !== exp_dout) $display("FAIL sw_dout: got %h exp %h", q, exp_dout); else n_pass++;
      @(negedge clk);
      n_checks++; if (ready !== 1'b0) $display("FAIL ready_pulse: got %b exp 0", ready); else n_pass++;
      access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rc, m, q, bo); exp_dout = 32'hDEADBEEF;
      n_checks++; if (rc !== WS + 2 || !bo || q !== 32'hDEADBEEF) $display("FAIL lw_100: cyc %0d busy_ok %0d dout %h exp %0d 1 deadbeef", rc, bo, q, WS + 2); else n_pass++;
      access(1'b1, 2'd0, 1'b0, 32'h103, 32'h000000AA, rc, m, q, bo); model_store(2'd0, 32'h103, 32'hAA);
      access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rc, m, q, bo);
      n_checks++; if (q !== 32'hAAADBEEF) $display("FAIL lw_after_sb: got %h exp aaadbeef", q); else n_pass++;
      access(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, rc, m, q, bo);
      n_checks++; if (q !== 32'hFFFFFFAA) $display("FAIL lb: got %h exp ffffffaa", q); else n_pass++;
      access(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, rc, m, q, bo);
      n_checks++; if (q !== 32'h000000AA) $display("FAIL lbu: got %h exp 000000aa", q); else n_pass++;
      access(1'b1, 2'd1, 1'b0, 32'h102, 32'h00008001, rc, m, q, bo); model_store(2'd1, 32'h102, 32'h8001);
      n_checks++; if (q !== 32'h000000AA) $display("FAIL sh_keeps_dout: got %h exp 000000aa", q); else n_pass++;
      access(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, rc, m, q, bo);
      n_checks++; if (q !== 32'hFFFF8001) $display("FAIL lh: got %h exp ffff8001", q); else n_pass++;
      access(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, rc, m, q, bo);
      n_checks++; if (q !== 32'h00008001) $display("FAIL lhu: got %h exp 00008001", q); else n_pass++;
      access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rc, m, q, bo); exp_dout = 32'h8001BEEF;
      n_checks++; if (q !== 32'h8001BEEF) $display("FAIL lw_after_sh: got %h exp 8001beef", q); else n_pass++;
   endtask

   task automatic test_misaligned;
      int rc; logic m, bo; logic [31:0] q;
      access(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, rc, m, q, bo);
      if (TRAP) begin
         n_checks++; if (rc !== 1 || m !== 1'b1 || !bo || q !== exp_dout) $display("FAIL lw_mis: cyc %0d mis %b busy_ok %0d dout %h exp 1 1 1 %h", rc, m, bo, q, exp_dout); else n_pass++;
         access(1'b1, 2'd1, 1'b0, 32'h103, 32'h0000FFFF, rc, m, q, bo);
         n_checks++; if (rc !== 1 || m !== 1'b1) $display("FAIL sh_mis: cyc %0d mis %b exp 1 1", rc, m); else n_pass++;
         access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rc, m, q, bo);
         n_checks++; if (q !== 32'h8001BEEF) $display("FAIL mem_after_mis: got %h exp 8001beef", q); else n_pass++;
      end else begin
         n_checks++; if (rc !== WS + 2 || m !== 1'b0 || q !== 32'h8001BEEF) $display("FAIL lw_trunc: cyc %0d mis %b dout %h exp %0d 0 8001beef", rc, m, q, WS + 2); else n_pass++;
      end
   endtask

   task automatic test_wrap;
      int rc; logic m, bo; logic [31:0] q;
      access(1'b1, 2'd2, 1'b0, 32'h1000, 32'hCAFEF00D, rc, m, q, bo); model_store(2'd2, 32'h1000, 32'hCAFEF00D);
      access(1'b0, 2'd2, 1'b0, 32'h0000, 32'h0, rc, m, q, bo); exp_dout = 32'hCAFEF00D;
      n_checks++; if (q !== 32'hCAFEF00D) $display("FAIL wrap: got %h exp cafef00d", q); else n_pass++;
   endtask

   task automatic test_reset_mid;
      int rc; logic m, bo, seen; logic [31:0] q;
      access(1'b1, 2'd2, 1'b0, 32'h200, 32'h0BADF00D, rc, m, q, bo); model_store(2'd2, 32'h200, 32'h0BADF00D);
      @(negedge clk);
      req = 1'b1; Mem_WrEn = 1'b1; size = 2'd2; ALU_MEM_Addr = 32'h200; MEM_DataIn = 32'h12345678;
      @(negedge clk);
      req = 1'b0;
      n_checks++; if (busy !== 1'b1) $display("FAIL mid_busy: got %b exp 1", busy); else n_pass++;
      reset = 1'b1; #1;
      exp_dout = '0;
      n_checks++; if ({busy, ready, misaligned, MEM_DataOut} !== 35'd0) $display("FAIL mid_reset_out: got %h exp 0", {busy, ready, misaligned, MEM_DataOut}); else n_pass++;
      @(negedge clk);
      reset = 1'b0; seen = 1'b0;
      repeat (4) begin @(negedge clk); if (ready || busy) seen = 1'b1; end
      n_checks++; if (seen !== 1'b0) $display("FAIL mid_no_ready: got %b exp 0", seen); else n_pass++;
      access(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, rc, m, q, bo); exp_dout = model_load(2'd2, 1'b0, 32'h200);
      n_checks++; if (q !== 32'h0BADF00D) $display("FAIL store_dropped: got %h exp 0badf00d", q); else n_pass++;
   endtask

   task automatic test_back_to_back;
      int rc, cyc; logic m, bo; logic [31:0] q, v0, v1;
      v0 = $urandom; v1 = $urandom;
      access(1'b1, 2'd2, 1'b0, 32'h340, v0, rc, m, q, bo); model_store(2'd2, 32'h340, v0);
      access(1'b1, 2'd2, 1'b0, 32'h344, v1, rc, m, q, bo); model_store(2'd2, 32'h344, v1);
      @(negedge clk);
      req = 1'b1; Mem_WrEn = 1'b0; size = 2'd2; sign_ext = 1'b0; ALU_MEM_Addr = 32'h340;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!ready && cyc < 20);
      n_checks++; if (cyc !== WS + 2 || MEM_DataOut !== model_load(2'd2, 1'b0, 32'h340)) $display("FAIL held_req: cyc %0d dout %h exp %0d %h", cyc, MEM_DataOut, WS + 2, v0); else n_pass++;
      ALU_MEM_Addr = 32'h344;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!ready && cyc < 20);
      n_checks++; if (cyc !== WS + 2 || MEM_DataOut !== model_load(2'd2, 1'b0, 32'h344)) $display("FAIL b2b: cyc %0d dout %h exp %0d %h", cyc, MEM_DataOut, WS + 2, v1); else n_pass++;
      req = 1'b0; exp_dout = v1;
      @(negedge clk);
      n_checks++; if (busy !== 1'b0 || ready !== 1'b0) $display("FAIL no_extra: busy %b ready %b exp 0 0", busy, ready); else n_pass++;
   endtask

   task automatic test_random;
      int rc, lat; logic m, bo, we, sx, em; logic [1:0] sz; logic [31:0] a, d, q;
      for (int i = 0; i < 16; i++) begin
         d = $urandom; a = 32'h300 + 32'(4 * i);
         access(1'b1, 2'd2, 1'b0, a, d, rc, m, q, bo); model_store(2'd2, a, d);
      end
      for (int i = 0; i < 60; i++) begin
         we = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3)); sx = 1'($urandom_range(0, 1));
         a  = (32'h300 + 32'($urandom_range(0, 63))) | ($urandom & 32'hFFFF_F000);
         d  = $urandom;
         em = model_mis(sz, a);
         lat = em ? 1 : WS + 2;
         access(we, sz, sx, a, d, rc, m, q, bo);
         if (!em) begin
            if (we) model_store(sz, a, d);
            else    exp_dout = model_load(sz, sx, a);
         end
         n_checks++; if (rc !== lat || m !== em || !bo) $display("FAIL rnd_hs[%0d]: cyc %0d mis %b busy_ok %0d exp %0d %b 1", i, rc, m, bo, lat, em); else n_pass++;
         n_checks++; if (q !== exp_dout) $display("FAIL rnd_dout[%0d]: we %b sz %0d a %h got %h exp %h", i, we, sz, a, q, exp_dout); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_misaligned();
      test_wrap();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
